// File: rtl/cmos_gate_tester.sv
// Self-test driver/checker for four-input complex CMOS gate cells: walks all 16
// input vectors, samples the cell output after a settle delay and scores it against TRUTH_TABLE.
module cmos_gate_tester #(
    parameter logic [15:0] TRUTH_TABLE   = 16'h0155,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       drv_a,
    output logic       drv_b,
    output logic       drv_c,
    output logic       drv_d,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // The down-counter is loaded with N-1 so SETTLE lasts exactly N cycles.
    localparam logic [3:0] SETTLE_LOAD =
        (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
    localparam logic       HAS_SETTLE  = (SETTLE_CYCLES != 0);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] vec_q;
    logic [3:0] settle_cnt_q;
    logic       accept;
    logic       mismatch;

    // NOTE: assign every always_comb output a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start)                state_d = APPLY;
            APPLY:      state_d = HAS_SETTLE ? SETTLE : SAMPLE;
            SETTLE:     if (settle_cnt_q == 4'd0) state_d = SAMPLE;
            SAMPLE:     state_d = (vec_q == 4'd15) ? DONE : APPLY;
            default:    state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign accept   = ((state_q == IDLE) || (state_q == DONE)) && start;
    // X/Z on the cell output must score as a failure, hence the case inequality.
    assign mismatch = (state_q == SAMPLE) && (y_in !== TRUTH_TABLE[vec_q]);

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q            <= 4'd0;
            settle_cnt_q     <= 4'd0;
            err_count        <= 5'd0;
            first_fail_vec   <= 4'd0;
            first_fail_valid <= 1'b0;
            done             <= 1'b0;
        end else begin
            if (accept) begin
                vec_q            <= 4'd0;
                err_count        <= 5'd0;
                first_fail_vec   <= 4'd0;
                first_fail_valid <= 1'b0;
                done             <= 1'b0;
            end

            if (state_q == APPLY) begin
                settle_cnt_q <= SETTLE_LOAD;
            end else if ((state_q == SETTLE) && (settle_cnt_q != 4'd0)) begin
                settle_cnt_q <= settle_cnt_q - 4'd1;
            end

            if (state_q == SAMPLE) begin
                if (mismatch) begin
                    if (err_count != 5'd16) begin
                        err_count <= err_count + 5'd1;
                    end
                    if (!first_fail_valid) begin
                        first_fail_vec   <= vec_q;
                        first_fail_valid <= 1'b1;
                    end
                end
                // The drives follow vec_q, so they only move on entry to the next APPLY.
                if (vec_q == 4'd15) begin
                    done <= 1'b1;
                end else begin
                    vec_q <= vec_q + 4'd1;
                end
            end
        end
    end

    assign {drv_a, drv_b, drv_c, drv_d} = vec_q;
    assign busy = (state_q == APPLY) || (state_q == SETTLE) || (state_q == SAMPLE);
    assign pass = done && (err_count == 5'd0);

endmodule

// File: tb/tb_cmos_gate_tester.sv
// Scoreboard bench for cmos_gate_tester: two instances (settle 2 and settle 0) driven by
// table-based gate models; expectations come from the gate equation, checked at each done rise.
module tb_cmos_gate_tester;

    localparam logic [15:0] TT = 16'h0155;
    localparam int S0 = 2;
    localparam int S1 = 0;

    typedef struct {
        int         acc;
        logic [4:0] err;
        logic [3:0] ffv;
        logic       ffval;
        logic       pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s[2];
    logic       a_s[2], b_s[2], c_s[2], d_s[2];
    logic       y_s[2];
    logic       busy_s[2], done_s[2], pass_s[2], ffval_s[2];
    logic [4:0] err_s[2];
    logic [3:0] ffv_s[2];
    logic [15:0] gtbl[2];
    logic       done_prev[2];

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign y_s[0] = gtbl[0][{a_s[0], b_s[0], c_s[0], d_s[0]}];
    assign y_s[1] = gtbl[1][{a_s[1], b_s[1], c_s[1], d_s[1]}];

    cmos_gate_tester #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(S0)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]),
        .drv_a(a_s[0]), .drv_b(b_s[0]), .drv_c(c_s[0]), .drv_d(d_s[0]),
        .y_in(y_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .err_count(err_s[0]), .first_fail_vec(ffv_s[0]), .first_fail_valid(ffval_s[0])
    );

    cmos_gate_tester #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]),
        .drv_a(a_s[1]), .drv_b(b_s[1]), .drv_c(c_s[1]), .drv_d(d_s[1]),
        .y_in(y_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .err_count(err_s[1]), .first_fail_vec(ffv_s[1]), .first_fail_valid(ffval_s[1])
    );

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int run_len(int i);
        return 16 * (((i == 0) ? S0 : S1) + 2);
    endfunction

    // Reference cell: Y = ~(D | (A & (B | C))) evaluated over every vector.
    function automatic logic [15:0] ref_tt();
        logic [15:0] t;
        logic [3:0]  v;
        t = '0;
        for (int k = 0; k < 16; k++) begin
            v = k[3:0];
            t[k] = ~(v[0] | (v[3] & (v[2] | v[1])));
        end
        return t;
    endfunction

    function automatic logic [15:0] ignore_d_tt();
        logic [15:0] t;
        logic [3:0]  v;
        t = '0;
        for (int k = 0; k < 16; k++) begin
            v = k[3:0];
            t[k] = ~(v[3] & (v[2] | v[1]));
        end
        return t;
    endfunction

    function automatic exp_t predict(logic [15:0] g, int acc);
        exp_t        e;
        logic [15:0] m;
        m       = g ^ ref_tt();
        e.acc   = acc;
        e.err   = 5'd0;
        e.ffv   = 4'd0;
        e.ffval = 1'b0;
        for (int v = 15; v >= 0; v--) begin
            if (m[v]) begin
                e.err   = e.err + 5'd1;
                e.ffv   = v[3:0];
                e.ffval = 1'b1;
            end
        end
        e.pass = (m == 16'd0);
        return e;
    endfunction

    function automatic int qsize(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(int i, exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic handle_done(int i);
        exp_t  e;
        int    have;
        string p;
        p    = $sformatf("dut%0d_", i);
        have = qsize(i);
        check({p, "done_expected"}, (have > 0) ? 1 : 0, 1);
        if (have > 0) begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            check({p, "latency"},          cyc - e.acc,   run_len(i));
            check({p, "err_count"},        err_s[i],      e.err);
            check({p, "first_fail_vec"},   ffv_s[i],      e.ffv);
            check({p, "first_fail_valid"}, ffval_s[i],    e.ffval);
            check({p, "pass"},             pass_s[i],     e.pass);
            check({p, "busy_in_done"},     busy_s[i],     0);
            check({p, "drv_hold_15"},      {a_s[i], b_s[i], c_s[i], d_s[i]}, 15);
        end
    endtask

    // Monitor: one scoreboard pop per rising edge of done.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done_s[i] && !done_prev[i] && !rst) handle_done(i);
            done_prev[i] <= done_s[i];
        end
    end

    task automatic wait_drain(int i);
        for (int k = 0; k < 400 && qsize(i) != 0; k++) @(negedge clk);
        check($sformatf("dut%0d_drain_timeout", i), qsize(i), 0);
        @(negedge clk);
    endtask

    task automatic run(int i, logic [15:0] g);
        int acc;
        gtbl[i] = g;
        @(negedge clk);
        start_s[i] = 1'b1;
        acc = cyc + 1;
        push(i, predict(g, acc));
        @(negedge clk);
        start_s[i] = 1'b0;
        wait_drain(i);
    endtask

    // start held across DONE: the second run begins on the edge after done rises.
    task automatic held_start(int i, logic [15:0] g);
        int acc;
        gtbl[i] = g;
        @(negedge clk);
        start_s[i] = 1'b1;
        acc = cyc + 1;
        push(i, predict(g, acc));
        push(i, predict(g, acc + run_len(i) + 1));
        while (cyc < acc + run_len(i) + 1) @(negedge clk);
        start_s[i] = 1'b0;
        check($sformatf("dut%0d_restart_err_clear", i), err_s[i], 0);
        check($sformatf("dut%0d_restart_done_clear", i), done_s[i], 0);
        check($sformatf("dut%0d_restart_busy", i), busy_s[i], 1);
        wait_drain(i);
    endtask

    task automatic check_cleared(string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_dut%0d_busy", tag, i),  busy_s[i],  0);
            check($sformatf("%s_dut%0d_done", tag, i),  done_s[i],  0);
            check($sformatf("%s_dut%0d_pass", tag, i),  pass_s[i],  0);
            check($sformatf("%s_dut%0d_err", tag, i),   err_s[i],   0);
            check($sformatf("%s_dut%0d_ffv", tag, i),   ffv_s[i],   0);
            check($sformatf("%s_dut%0d_ffval", tag, i), ffval_s[i], 0);
            check($sformatf("%s_dut%0d_drv", tag, i), {a_s[i], b_s[i], c_s[i], d_s[i]}, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int          acc;
        logic [15:0] g;
        rst          = 1'b1;
        start_s[0]   = 1'b0;
        start_s[1]   = 1'b0;
        gtbl[0]      = ref_tt();
        gtbl[1]      = ref_tt();
        done_prev[0] = 1'b0;
        done_prev[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        // Directed cell models on the settle-2 instance.
        run(0, ref_tt());
        run(0, 16'h0000);
        run(0, 16'hFFFF);
        run(0, ignore_d_tt());

        for (int k = 0; k < 6; k++) begin
            g = $urandom();
            if (k % 2 == 0) g = ref_tt() ^ (16'd1 << $urandom_range(0, 15));
            run(0, g);
        end

        // Reset 20 cycles into a run, with start asserted alongside: reset wins.
        gtbl[0] = 16'h0000;
        @(negedge clk);
        start_s[0] = 1'b1;
        acc = cyc + 1;
        push(0, predict(gtbl[0], acc));
        @(negedge clk);
        start_s[0] = 1'b0;
        while (cyc < acc + 20) @(negedge clk);
        rst        = 1'b1;
        start_s[0] = 1'b1;
        @(negedge clk);
        check_cleared("midrun_rst");
        rst        = 1'b0;
        start_s[0] = 1'b0;
        q0.delete();
        run(0, ref_tt());

        // Stray start pulses during a run must not disturb it.
        gtbl[0] = ignore_d_tt();
        @(negedge clk);
        start_s[0] = 1'b1;
        acc = cyc + 1;
        push(0, predict(gtbl[0], acc));
        @(negedge clk);
        start_s[0] = 1'b0;
        while (cyc < acc + 5) @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        while (cyc < acc + 30) @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_drain(0);

        held_start(0, 16'h0000);

        // Zero-settle instance.
        run(1, ref_tt());
        run(1, 16'hFFFF);
        for (int k = 0; k < 4; k++) run(1, 16'($urandom()));
        held_start(1, ignore_d_tt());

        repeat (4) @(negedge clk);
        check("dut0_spurious_pending", q0.size(), 0);
        check("dut1_spurious_pending", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
